r_channel: RTL and testbench

//  AXI4-Lite read-data (R) channel stage; sits directly downstream of the AR channel stage.

---
 rtl/axil_pkg.sv | 19 +
 rtl/axil_tmo_counter.sv | 31 +++
 rtl/r_channel.sv | 132 +++++++++++++
 tb/tb_r_channel.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions used by the channel stages.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    WAIT_R = 1'b1
  } r_state_t;

  // SLVERR and DECERR both carry bit 1 set.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axil_tmo_counter.sv
// Clearable, enabled wait counter with a terminal-count flag for response timeouts.
module axil_tmo_counter #(
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned CNT_W       = 9
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam bit              TMO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TERM_VAL = TMO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // A zero timeout never reaches terminal count, so the wait is unbounded.
  assign o_terminal = TMO_EN && (r_count == TERM_VAL);

endmodule

// File: rtl/r_channel.sv
// AXI4-Lite read-data channel stage: arms on AR completion, captures one beat,
// reports done/err/timeout pulses and a sticky stray-beat flag.
module r_channel
  import axil_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned CNT_W       = 9
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_arm,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_rresp,
  input  logic              i_rvalid,
  output logic              o_rready,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_resp,
  output logic              o_done,
  output logic              o_err,
  output logic              o_timeout,
  output logic              o_busy,
  output logic              o_stray
);

  r_state_t r_state;
  r_state_t w_state_next;

  logic              r_arm_q;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_done;
  logic              r_err;
  logic              r_timeout;
  logic              r_stray;

  logic w_start;
  logic w_busy;
  logic w_handshake;
  logic w_capture;
  logic w_tmo_fire;
  logic w_cnt_clear;
  logic w_cnt_en;
  logic w_terminal;

  assign w_start     = i_arm & ~r_arm_q;
  assign w_busy      = (r_state == WAIT_R);
  assign w_handshake = i_rvalid & w_busy;

  axil_tmo_counter #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_tmo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clear    (w_cnt_clear),
    .i_enable   (w_cnt_en),
    .o_terminal (w_terminal)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A beat arriving on the terminal cycle still completes; handshake has priority.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_tmo_fire   = 1'b0;
    w_cnt_clear  = 1'b0;
    w_cnt_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_next = WAIT_R;
          w_cnt_clear  = 1'b1;
        end
      end
      WAIT_R: begin
        if (w_handshake) begin
          w_capture    = 1'b1;
          w_state_next = IDLE;
        end else if (w_terminal) begin
          w_tmo_fire   = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_arm_q   <= 1'b0;
      r_data    <= '0;
      r_resp    <= RESP_OKAY;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_stray   <= 1'b0;
    end else begin
      r_arm_q   <= i_arm;
      r_done    <= w_capture;
      r_err     <= w_capture & resp_is_err(i_rresp);
      r_timeout <= w_tmo_fire;
      if (w_capture) begin
        r_data <= i_rdata;
        r_resp <= i_rresp;
      end
      // Data is kept across a timeout so the last good capture stays visible.
      if (i_rvalid && !w_busy) begin
        r_stray <= 1'b1;
      end
    end
  end

  assign o_rready  = w_busy;
  assign o_busy    = w_busy;
  assign o_data    = r_data;
  assign o_resp    = r_resp;
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_timeout = r_timeout;
  assign o_stray   = r_stray;

endmodule

// File: tb/tb_r_channel.sv
// Self-checking bench for r_channel: directed scenarios plus randomized reads
// checked against a transaction-level expectation of each read's outcome.
module tb_r_channel;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TMO    = 8;
  localparam int unsigned CNT_W  = 9;

  logic              clk;
  logic              reset;
  logic              arm;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] data;
  logic [1:0]        resp;
  logic              done;
  logic              err;
  logic              timeout;
  logic              busy;
  logic              stray;

  int assertCount = 0;
  int failCount   = 0;

  logic [DATA_W-1:0] expData  = '0;
  logic [1:0]        expResp  = 2'b00;
  logic              expStray = 1'b0;

  r_channel #(
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TMO),
    .CNT_W       (CNT_W)
  ) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_arm     (arm),
    .i_rdata   (rdata),
    .i_rresp   (rresp),
    .i_rvalid  (rvalid),
    .o_rready  (rready),
    .o_data    (data),
    .o_resp    (resp),
    .o_done    (done),
    .o_err     (err),
    .o_timeout (timeout),
    .o_busy    (busy),
    .o_stray   (stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic [1:0] r);
    rvalid = v;
    rdata  = d;
    rresp  = r;
  endtask

  // One read: arm edge, beat offered after 'delay' WAIT_R cycles (never if delay >= TMO).
  task automatic runRead(input string tag, input int delay, input logic [DATA_W-1:0] d, input logic [1:0] r);
    int  rHigh;
    int  doneCnt;
    int  errCnt;
    int  loneErr;
    int  tmoCnt;
    int  i;
    bit  finished;
    bit  hit;
    hit      = (delay < int'(TMO));
    rHigh    = 0;
    doneCnt  = 0;
    errCnt   = 0;
    loneErr  = 0;
    tmoCnt   = 0;
    finished = 1'b0;
    i        = 0;
    arm = 1'b0;
    applyStimulus(1'b0, $urandom, 2'b00);
    tick();
    arm = 1'b1;
    tick();
    while (!finished && i < 64) begin
      if (rready) rHigh++;
      if (i == delay) applyStimulus(1'b1, d, r);
      tick();
      if (done) doneCnt++;
      if (err && done) errCnt++;
      if (err && !done) loneErr++;
      if (timeout) tmoCnt++;
      if (!rready) finished = 1'b1;
      i++;
    end
    applyStimulus(1'b0, $urandom, 2'b00);
    if (hit) begin
      expData = d;
      expResp = r;
    end
    checkOutput({tag, ".finished"}, 32'(finished), 32'd1);
    checkOutput({tag, ".rreadyCycles"}, rHigh, hit ? delay + 1 : int'(TMO));
    checkOutput({tag, ".doneCount"}, doneCnt, hit ? 1 : 0);
    checkOutput({tag, ".errCount"}, errCnt, (hit && r[1]) ? 1 : 0);
    checkOutput({tag, ".loneErr"}, loneErr, 0);
    checkOutput({tag, ".timeoutCount"}, tmoCnt, hit ? 0 : 1);
    checkOutput({tag, ".data"}, data, expData);
    checkOutput({tag, ".resp"}, 32'(resp), 32'(expResp));
    checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
    checkOutput({tag, ".stray"}, 32'(stray), 32'(expStray));
    tick();
    checkOutput({tag, ".donePulse"}, 32'(done), 32'd0);
    checkOutput({tag, ".timeoutPulse"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    int extraDone;
    reset = 1'b0;
    arm   = 1'b0;
    applyStimulus(1'b0, '0, 2'b00);
    tick();
    tick();
    checkOutput("reset.rready", 32'(rready), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.data", data, 32'd0);
    checkOutput("reset.resp", 32'(resp), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.err", 32'(err), 32'd0);
    checkOutput("reset.timeout", 32'(timeout), 32'd0);
    checkOutput("reset.stray", 32'(stray), 32'd0);
    reset = 1'b1;
    tick();

    $display("[TB] OKAY read with one-cycle beat delay");
    runRead("okay", 1, 32'hDEADBEEF, 2'b00);

    $display("[TB] SLVERR read");
    runRead("slverr", 1, 32'hCAFEF00D, 2'b10);

    $display("[TB] timeout with no beat");
    runRead("tmo", 20, 32'h12345678, 2'b00);

    $display("[TB] beat on terminal cycle");
    runRead("termHit", int'(TMO) - 1, 32'hA5A5A5A5, 2'b01);

    $display("[TB] zero-delay beat");
    runRead("fast", 0, 32'h0BADF00D, 2'b11);

    $display("[TB] arm held high");
    extraDone = 0;
    arm = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (done) extraDone++;
    end
    checkOutput("armHeld.extraDone", extraDone, 0);
    checkOutput("armHeld.busy", 32'(busy), 32'd0);

    $display("[TB] stray beat while idle");
    checkOutput("stray.before", 32'(stray), 32'd0);
    applyStimulus(1'b1, 32'hFFFFFFFF, 2'b00);
    tick();
    applyStimulus(1'b0, '0, 2'b00);
    tick();
    expStray = 1'b1;
    checkOutput("stray.set", 32'(stray), 32'd1);
    checkOutput("stray.dataUntouched", data, expData);
    for (int k = 0; k < 5; k++) tick();
    checkOutput("stray.sticky", 32'(stray), 32'd1);
    runRead("afterStray", 3, 32'h13579BDF, 2'b00);

    $display("[TB] reset during WAIT_R");
    arm = 1'b0;
    tick();
    arm = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("midReset.busyBefore", 32'(busy), 32'd1);
    reset = 1'b0;
    arm   = 1'b0;
    tick();
    reset = 1'b1;
    expData  = '0;
    expResp  = 2'b00;
    expStray = 1'b0;
    checkOutput("midReset.rready", 32'(rready), 32'd0);
    checkOutput("midReset.busy", 32'(busy), 32'd0);
    checkOutput("midReset.data", data, 32'd0);
    checkOutput("midReset.resp", 32'(resp), 32'd0);
    checkOutput("midReset.done", 32'(done), 32'd0);
    checkOutput("midReset.timeout", 32'(timeout), 32'd0);
    checkOutput("midReset.stray", 32'(stray), 32'd0);
    runRead("postReset", 2, 32'h2468ACE0, 2'b00);

    $display("[TB] randomized reads");
    for (int n = 0; n < 16; n++) begin
      runRead($sformatf("rand%0d", n), int'($urandom_range(0, 11)), $urandom, 2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
